// File: rtl/conv_mem_host.sv
// conv_mem_host: responder end of the CONV accelerator memory/handshake port.
// Holds the image ROM, the layer-0/1 banks and the layer-2 buffer, frames a
// run from the busy handshake, reports done/err and offers a dump readback.
module conv_mem_host #(
  parameter int DW      = 20,
  parameter int AW      = 12,
  parameter int TIMEOUT = 1048575
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          img_we,
  input  logic [AW-1:0] img_waddr,
  input  logic [DW-1:0] img_wdata,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic [2:0]    csel,
  output logic          done,
  output logic          err,
  input  logic [2:0]    dump_sel,
  input  logic [AW-1:0] dump_addr,
  output logic [DW-1:0] dump_data
);

  localparam int DEPTH_IMG = 4096;
  localparam int DEPTH_L0  = 4096;
  localparam int DEPTH_L1  = 1024;
  localparam int DEPTH_L2  = 2048;
  localparam int CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic [DW-1:0] img  [DEPTH_IMG];
  logic [DW-1:0] l0k0 [DEPTH_L0];
  logic [DW-1:0] l0k1 [DEPTH_L0];
  logic [DW-1:0] l1k0 [DEPTH_L1];
  logic [DW-1:0] l1k1 [DEPTH_L1];
  logic [DW-1:0] l2   [DEPTH_L2];

  logic wr_ok;
  logic img_wr_ok;
  logic err_hit;
  logic timeout_hit;

  // An address is only usable if the selected bank is real and deep enough.
  function automatic logic legal(input logic [2:0] sel, input logic [AW-1:0] addr);
    case (sel)
      3'd1, 3'd2: legal = int'(addr) < DEPTH_L0;
      3'd3, 3'd4: legal = int'(addr) < DEPTH_L1;
      3'd5:       legal = int'(addr) < DEPTH_L2;
      default:    legal = 1'b0;
    endcase
  endfunction

  assign wr_ok     = !reset && cwr && (state == RUN) && legal(csel, caddr_wr);
  assign img_wr_ok = !reset && img_we && (state == IDLE);

  assign err_hit = (cwr && ((state != RUN) || !legal(csel, caddr_wr))) ||
                   (crd && !legal(csel, caddr_rd)) ||
                   (img_we && (state != IDLE));

  assign timeout_hit = (cnt == CNT_LAST) &&
                       (((state == ARM) && !busy) || ((state == RUN) && busy));

  // Image read is only exposed while CONV owns the image (ARM or RUN).
  always_comb begin
    idata = '0;
    if (!reset && ((state == ARM) || (state == RUN))) begin
      idata = img[iaddr];
    end
  end

  // Layer read port: zero latency, so a same-cycle write still shows the old word.
  always_comb begin
    cdata_rd = '0;
    if (!reset && crd && legal(csel, caddr_rd)) begin
      case (csel)
        3'd1:    cdata_rd = l0k0[caddr_rd[11:0]];
        3'd2:    cdata_rd = l0k1[caddr_rd[11:0]];
        3'd3:    cdata_rd = l1k0[caddr_rd[9:0]];
        3'd4:    cdata_rd = l1k1[caddr_rd[9:0]];
        3'd5:    cdata_rd = l2[caddr_rd[10:0]];
        default: cdata_rd = '0;
      endcase
    end
  end

  // Dump readback is always live so results can be pulled in any state.
  always_comb begin
    dump_data = '0;
    if (!reset && legal(dump_sel, dump_addr)) begin
      case (dump_sel)
        3'd1:    dump_data = l0k0[dump_addr[11:0]];
        3'd2:    dump_data = l0k1[dump_addr[11:0]];
        3'd3:    dump_data = l1k0[dump_addr[9:0]];
        3'd4:    dump_data = l1k1[dump_addr[9:0]];
        3'd5:    dump_data = l2[dump_addr[10:0]];
        default: dump_data = '0;
      endcase
    end
  end

  // Memory writes: image preload in IDLE, layer writes steered by csel in RUN.
  always_ff @(posedge clk) begin
    if (img_wr_ok) begin
      img[img_waddr] <= img_wdata;
    end
    if (wr_ok) begin
      case (csel)
        3'd1:    l0k0[caddr_wr[11:0]] <= cdata_wr;
        3'd2:    l0k1[caddr_wr[11:0]] <= cdata_wr;
        3'd3:    l1k0[caddr_wr[9:0]]  <= cdata_wr;
        3'd4:    l1k1[caddr_wr[9:0]]  <= cdata_wr;
        3'd5:    l2[caddr_wr[10:0]]   <= cdata_wr;
        default: ;
      endcase
    end
  end

  // Run framing FSM with registered ready/done and the sticky err flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ready <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (start) begin
            state <= ARM;
            ready <= 1'b1;
            cnt   <= '0;
          end
        end
        ARM: begin
          if (busy) begin
            state <= RUN;
            ready <= 1'b0;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            ready <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!busy) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase

      if ((state == IDLE) && start) begin
        err <= err_hit;
      end else if (err_hit || timeout_hit) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_mem_host.sv
// tb_conv_mem_host: self-checking bench for conv_mem_host. A main instance
// exercises handshake, steering and error rules against a keyed memory model;
// a second instance with a short timeout covers the watchdog.
module tb_conv_mem_host;

  logic        clk = 1'b0;
  logic        reset, start, img_we, busy, cwr, crd;
  logic [11:0] img_waddr, iaddr, caddr_wr, caddr_rd, dump_addr;
  logic [19:0] img_wdata, cdata_wr;
  logic [2:0]  csel, dump_sel;

  logic        ready, done, err;
  logic [19:0] idata, cdata_rd, dump_data;
  logic        ready_t, done_t, err_t;
  logic [19:0] idata_t, cdata_rd_t, dump_data_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [19:0] mem_m [int];
  logic [19:0] img_m [int];
  logic        err_m;
  bit          in_run;

  // Free-running clock shared by both instances.
  always #5 clk = ~clk;

  conv_mem_host #(.DW(20), .AW(12), .TIMEOUT(1000)) dut (
    .clk(clk), .reset(reset), .start(start),
    .img_we(img_we), .img_waddr(img_waddr), .img_wdata(img_wdata),
    .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
    .done(done), .err(err),
    .dump_sel(dump_sel), .dump_addr(dump_addr), .dump_data(dump_data)
  );

  conv_mem_host #(.DW(20), .AW(12), .TIMEOUT(8)) dut_to (
    .clk(clk), .reset(reset), .start(start),
    .img_we(img_we), .img_waddr(img_waddr), .img_wdata(img_wdata),
    .ready(ready_t), .busy(busy), .iaddr(iaddr), .idata(idata_t),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd_t), .csel(csel),
    .done(done_t), .err(err_t),
    .dump_sel(dump_sel), .dump_addr(dump_addr), .dump_data(dump_data_t)
  );

  function automatic int depth_of(input logic [2:0] sel);
    case (sel)
      3'd1, 3'd2: return 4096;
      3'd3, 3'd4: return 1024;
      3'd5:       return 2048;
      default:    return 0;
    endcase
  endfunction

  function automatic bit legal_m(input logic [2:0] sel, input logic [11:0] a);
    return int'(a) < depth_of(sel);
  endfunction

  function automatic int key(input logic [2:0] sel, input logic [11:0] a);
    return int'(sel) * 4096 + int'(a);
  endfunction

  function automatic logic [11:0] pick_addr();
    logic [11:0] edges [7] = '{12'd0, 12'd1, 12'd1023, 12'd1024, 12'd2047, 12'd2048, 12'd4095};
    if ($urandom_range(0, 1) == 1) return edges[$urandom_range(0, 6)];
    return 12'($urandom_range(0, 4095));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // One layer-port cycle: check the read against the model, then the err flag.
  task automatic applyStimulus(input logic w, input logic [2:0] sel, input logic [11:0] wa,
                               input logic [19:0] wd, input logic r, input logic [11:0] ra,
                               input string tag);
    logic [19:0] exp_rd;
    bit          known;
    cwr = w; csel = sel; caddr_wr = wa; cdata_wr = wd; crd = r; caddr_rd = ra;
    settle();
    known  = 1;
    exp_rd = '0;
    if (r && legal_m(sel, ra)) begin
      if (mem_m.exists(key(sel, ra))) exp_rd = mem_m[key(sel, ra)];
      else known = 0;
    end
    if (known) checkOutput({tag, "_rd"}, cdata_rd, exp_rd);
    if ((w && (!in_run || !legal_m(sel, wa))) || (r && !legal_m(sel, ra))) err_m = 1'b1;
    tick();
    if (w && in_run && legal_m(sel, wa)) mem_m[key(sel, wa)] = wd;
    cwr = 1'b0;
    crd = 1'b0;
    checkOutput({tag, "_err"}, err, err_m);
  endtask

  task automatic checkDump(input logic [2:0] sel, input logic [11:0] a, input string tag);
    dump_sel  = sel;
    dump_addr = a;
    settle();
    if (!legal_m(sel, a)) checkOutput(tag, dump_data, 20'h0);
    else if (mem_m.exists(key(sel, a))) checkOutput(tag, dump_data, mem_m[key(sel, a)]);
    tick();
  endtask

  task automatic startRun();
    start = 1'b1;
    tick();
    start = 1'b0;
    err_m = 1'b0;
    checkOutput("err_clr", err, err_m);
    checkOutput("ready_arm", ready, 1'b1);
    busy = 1'b1;
    tick();
    in_run = 1;
    checkOutput("ready_run", ready, 1'b0);
  endtask

  task automatic endRun();
    busy = 1'b0;
    settle();
    checkOutput("done_pre", done, 1'b0);
    tick();
    in_run = 0;
    checkOutput("done", done, 1'b1);
    checkOutput("err_run", err, err_m);
    tick();
    checkOutput("done_off", done, 1'b0);
  endtask

  task automatic doReset();
    busy  = 1'b0;
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    err_m  = 1'b0;
    in_run = 0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; img_we = 1'b0; busy = 1'b0; cwr = 1'b0; crd = 1'b1;
    img_waddr = '0; iaddr = '0; caddr_wr = '0; caddr_rd = 12'd5; dump_addr = 12'd5;
    img_wdata = '0; cdata_wr = '0; csel = 3'd1; dump_sel = 3'd1;
    err_m = 1'b0; in_run = 0;

    // Reset cycle: all read data forced to zero, then flags clear.
    settle();
    checkOutput("rst_idata", idata, 20'h0);
    checkOutput("rst_cdata", cdata_rd, 20'h0);
    checkOutput("rst_dump", dump_data, 20'h0);
    crd = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("rst_ready", ready, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_err", err, 1'b0);

    // Image preload in IDLE.
    img_we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      img_waddr = 12'(i);
      img_wdata = (i == 0) ? 20'h0A000 : 20'($urandom);
      img_m[i]  = img_wdata;
      tick();
    end
    img_we = 1'b0;
    iaddr  = 12'd0;
    settle();
    checkOutput("idata_idle", idata, 20'h0);
    checkOutput("err_preload", err, 1'b0);

    // Handshake: busy rises three cycles after start, ready holds four cycles.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iaddr = 12'(i * 3);
      settle();
      checkOutput("ready_hs", ready, 1'b1);
      checkOutput("idata_arm", idata, img_m[i * 3]);
      tick();
      if (i == 2) busy = 1'b1;
    end
    checkOutput("ready_hs_drop", ready, 1'b0);
    in_run = 1;
    iaddr  = 12'd0;
    settle();
    checkOutput("idata_run", idata, 20'h0A000);

    // Bank steering and read-before-write inside the run.
    applyStimulus(1'b1, 3'd1, 12'd6, 20'h00777, 1'b0, 12'd0, "wr_l0k0_6");
    applyStimulus(1'b1, 3'd1, 12'd5, 20'h00123, 1'b0, 12'd0, "wr_l0k0_5");
    applyStimulus(1'b1, 3'd2, 12'd5, 20'h00456, 1'b0, 12'd0, "wr_l0k1_5");
    applyStimulus(1'b1, 3'd5, 12'd2047, 20'hFFFFF, 1'b0, 12'd0, "wr_l2_top");
    applyStimulus(1'b1, 3'd3, 12'd7, 20'h00011, 1'b0, 12'd0, "wr_l1k0_old");
    applyStimulus(1'b1, 3'd3, 12'd7, 20'h00022, 1'b1, 12'd7, "rbw_same");
    applyStimulus(1'b0, 3'd3, 12'd0, 20'h0, 1'b1, 12'd7, "rbw_next");
    tick();
    tick();
    endRun();

    checkDump(3'd1, 12'd5, "dump_l0k0_5");
    checkDump(3'd2, 12'd5, "dump_l0k1_5");
    checkDump(3'd5, 12'd2047, "dump_l2_top");
    checkDump(3'd1, 12'd6, "dump_l0k0_6");
    checkDump(3'd3, 12'd7, "dump_l1k0_7");
    checkDump(3'd5, 12'd2048, "dump_l2_oob");
    checkDump(3'd0, 12'd5, "dump_sel0");
    applyStimulus(1'b0, 3'd1, 12'd0, 20'h0, 1'b1, 12'd5, "rd_idle");

    // Illegal accesses: out-of-range write in RUN, then write in IDLE.
    startRun();
    applyStimulus(1'b1, 3'd4, 12'd0, 20'h0ABCD, 1'b0, 12'd0, "wr_l1k1_0");
    applyStimulus(1'b1, 3'd4, 12'd1024, 20'h55555, 1'b0, 12'd0, "wr_l1k1_oob");
    checkDump(3'd4, 12'd0, "dump_l1k1_0");
    endRun();
    startRun();
    endRun();
    applyStimulus(1'b1, 3'd1, 12'd5, 20'h99999, 1'b0, 12'd0, "wr_idle");
    checkDump(3'd1, 12'd5, "dump_after_idle_wr");

    // Randomized layer traffic against the keyed model.
    doReset();
    startRun();
    begin
      logic [2:0]  last_sel;
      logic [11:0] last_wa;
      last_sel = 3'd1;
      last_wa  = 12'd5;
      for (int i = 0; i < 40; i++) begin
        logic [2:0]  ws, rs;
        logic [11:0] wa, ra;
        bit          w, r;
        ws = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(1, 5)) : 3'($urandom_range(0, 7));
        wa = pick_addr();
        w  = $urandom_range(0, 3) != 0;
        r  = $urandom_range(0, 1) == 1;
        rs = r ? last_sel : ws;
        ra = r ? last_wa : pick_addr();
        if (r) ws = rs;
        applyStimulus(w, ws, wa, 20'($urandom), r, ra, "rand");
        if (w) begin
          last_sel = ws;
          last_wa  = wa;
        end
      end
    end
    endRun();
    for (int i = 0; i < 12; i++) begin
      checkDump(3'($urandom_range(0, 7)), pick_addr(), "dump_rand");
    end

    // Watchdog on the short-timeout instance: eight ARM cycles then err.
    doReset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput("to_ready", ready_t, 1'b1);
      checkOutput("to_err_low", err_t, 1'b0);
      tick();
    end
    checkOutput("to_err", err_t, 1'b1);
    checkOutput("to_idle", ready_t, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("to_err_clr", err_t, 1'b0);
    checkOutput("to_rearm", ready_t, 1'b1);

    // Reset in the middle of a run keeps memory but clears the flags.
    doReset();
    startRun();
    applyStimulus(1'b1, 3'd5, 12'd100, 20'h0BEEF, 1'b0, 12'd0, "wr_l2_100");
    applyStimulus(1'b0, 3'd0, 12'd0, 20'h0, 1'b1, 12'd3, "rd_badsel");
    reset = 1'b1; crd = 1'b1; csel = 3'd5; caddr_rd = 12'd100; iaddr = 12'd0;
    dump_sel = 3'd5; dump_addr = 12'd100;
    settle();
    checkOutput("midrst_idata", idata, 20'h0);
    checkOutput("midrst_cdata", cdata_rd, 20'h0);
    checkOutput("midrst_dump", dump_data, 20'h0);
    tick();
    reset = 1'b0; busy = 1'b0; crd = 1'b0; err_m = 1'b0; in_run = 0;
    checkOutput("midrst_ready", ready, 1'b0);
    checkOutput("midrst_done", done, 1'b0);
    checkOutput("midrst_err", err, 1'b0);
    checkDump(3'd5, 12'd100, "dump_partial");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_mem_host.md
Name: conv_mem_host

Overview:
- Responder end of the CONV accelerator's memory and handshake interface.
- Holds the 64x64 input image ROM, the two layer-0 banks, the two layer-1 banks and the layer-2 buffer.
- Drives ready, serves idata, cdata_rd and iaddr-driven reads, and absorbs cwr writes steered by csel.
- Watches busy to frame a run, reports done and err, and exposes a dump port for result readback by the system or bench.

Parameters:
- DW, 20, data width of every memory word.
- AW, 12, address width of iaddr, caddr_wr, caddr_rd.
- TIMEOUT, 1048575, maximum cycles to wait for a busy edge before flagging err.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse: arm a new run.
- img_we  in  1  image preload write enable.
- img_waddr  in  12  image preload address.
- img_wdata  in  20  image preload data.
- ready  out  1  to CONV: image available.
- busy  in  1  from CONV: run in progress.
- iaddr  in  12  image read address.
- idata  out  20  image read data.
- cwr  in  1  layer write enable.
- caddr_wr  in  12  layer write address.
- cdata_wr  in  20  layer write data.
- crd  in  1  layer read enable.
- caddr_rd  in  12  layer read address.
- cdata_rd  out  20  layer read data.
- csel  in  3  bank select: 1=L0k0, 2=L0k1, 3=L1k0, 4=L1k1, 5=L2.
- done  out  1  one-cycle pulse at end of run.
- err  out  1  sticky protocol error flag.
- dump_sel  in  3  bank select for readback, same encoding as csel.
- dump_addr  in  12  readback address.
- dump_data  out  20  readback data.

Behaviour:
- Bank depths:
  - image 4096; L0k0 and L0k1 4096 each; L1k0 and L1k1 1024 each; L2 2048.
  - Address legal iff below the bank depth.
- Reset:
  - state=IDLE; ready=0, done=0, err=0; timeout counter=0.
  - idata, cdata_rd and dump_data evaluate to 0 from the reset cycle on.
  - Memory contents are not cleared.
- Reads are combinational from the current address and select (zero latency):
  - idata = img[iaddr] while state is ARM or RUN, else 0.
  - cdata_rd = bank(csel)[caddr_rd] when crd=1, csel is 1..5 and the address is legal, else 0.
  - dump_data = bank(dump_sel)[dump_addr] under the same legality rule; it is always live.
- Writes land on the rising edge:
  - Condition: cwr=1 in RUN, csel 1..5, legal address.
  - Action: bank(csel)[caddr_wr] <= cdata_wr.
- Same-bank, same-address cwr and crd in one cycle: cdata_rd returns the old word; the new word is visible the next cycle.
- State machine:
  - IDLE: ready=0.
    - start=1 -> ARM; counter cleared.
    - img_we=1 writes img[img_waddr] <= img_wdata.
  - ARM: ready=1; counter increments.
    - busy sampled 1 -> RUN; ready drops to 0 on that same edge, i.e. 0 from the next cycle.
    - counter reaches TIMEOUT -> err=1 and state -> IDLE.
  - RUN: ready=0; counter cleared on entry, then increments.
    - busy sampled 0 -> DONE.
    - counter reaches TIMEOUT -> err=1 and state -> IDLE.
  - DONE: done=1 for exactly this cycle -> IDLE.
- busy already high when ARM is entered: counts as seen; RUN is entered next edge.
- Conditions that set err (sticky, cleared only by reset or by start accepted in IDLE):
  - cwr=1 outside RUN: write ignored.
  - cwr=1 with csel 0, 6 or 7: write ignored.
  - cwr=1 with an out-of-range address: write ignored.
  - crd=1 with an illegal select or address.
  - img_we=1 outside IDLE: write ignored.
- start outside IDLE: ignored, no error.
- reset mid-run: returns to IDLE next edge with ready=0; memory holds partial results.
- A start accepted in IDLE clears err on the same edge; an err condition in that same cycle wins.

Test Plan:
- Handshake:
  - Stimulus: preload img[0]=20'h0A000, pulse start, CONV model raises busy 3 cycles later.
  - Required: ready=1 for 4 cycles then 0.
- Image read and done:
  - Stimulus: with iaddr=0, hold busy 10 cycles, then drop it.
  - Required: idata=20'h0A000; done pulses exactly one cycle after busy is sampled low; err=0.
- Bank steering:
  - Stimulus: in RUN, write csel=1 addr 5 data 20'h00123, csel=2 addr 5 data 20'h00456, csel=5 addr 2047 data 20'hFFFFF.
  - Required: dump reads return those three values; L0k0[6] is unchanged.
- Read-before-write:
  - Stimulus: same cycle cwr and crd, csel=3, addr 7, old 20'h00011, new 20'h00022.
  - Required: cdata_rd=20'h00011 that cycle, 20'h00022 the next.
- Illegal access:
  - Stimulus: csel=4, caddr_wr=1024, cwr=1.
  - Required: no write and err=1.
  - Stimulus: cwr=1 in IDLE.
  - Required: err=1 and the memory is unchanged.
- Timeout and reset:
  - Stimulus: TIMEOUT=8, start, busy held 0.
  - Required: err=1 after 8 ARM cycles and state IDLE.
  - Stimulus: a new start.
  - Required: err clears.
  - Stimulus: reset asserted mid-RUN.
  - Required: ready=0, done=0 and err=0 next cycle.
